// File: rtl/cache_fill_if.sv
// Bus between the cache-fill FSM, the tag-compare logic, the 4-cycle memory
// and the cache data/tag arrays. The fill FSM sits on the master side.
interface cache_fill_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    // Miss request from tag compare
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;

    // Memory read return path
    logic [15:0]           memory_data;
    logic                  memory_data_valid;

    // Memory request path
    logic                  mem_enable;
    logic [ADDR_WIDTH-1:0] memory_address;

    // Cache array write side
    logic                  fsm_busy;
    logic                  write_data_array;
    logic [2:0]            data_word_sel;
    logic [15:0]           fill_data;
    logic                  write_tag_array;
    logic [ADDR_WIDTH-5:0] fill_block_addr;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_data,
        input  memory_data_valid,
        output mem_enable,
        output memory_address,
        output fsm_busy,
        output write_data_array,
        output data_word_sel,
        output fill_data,
        output write_tag_array,
        output fill_block_addr
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output memory_data,
        output memory_data_valid,
        input  mem_enable,
        input  memory_address,
        input  fsm_busy,
        input  write_data_array,
        input  data_word_sel,
        input  fill_data,
        input  write_tag_array,
        input  fill_block_addr
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller. On a miss it issues eight back-to-back word
// reads to a pipelined memory, writes each returning word into the data
// array, and writes the tag/valid entry together with the last word.
module cache_fill_fsm #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8
) (
    input logic        clk,
    input logic        rst_n,
    cache_fill_if.master bus
);

    // Index of the last 16-bit word in a block; counters are 3 bits wide.
    localparam logic [2:0] LastWord = 3'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            issue_cnt_q, issue_cnt_d;
    logic [2:0]            return_cnt_q, return_cnt_d;
    logic [ADDR_WIDTH-5:0] block_addr_q, block_addr_d;

    logic accept;
    logic last_return;

    // Byte offset within the block is not needed: the fill always starts at word 0.
    logic unused_low_addr;
    assign unused_low_addr = ^bus.miss_address[3:0];

    // Return data is only meaningful while a fill is outstanding; valids in
    // idle are stale or spurious and are dropped.
    assign accept      = bus.memory_data_valid && (state_q != StIdle);
    assign last_return = accept && (return_cnt_q == LastWord);

    // State, counters and latched block address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            issue_cnt_q  <= '0;
            return_cnt_q <= '0;
            block_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            return_cnt_q <= return_cnt_d;
            block_addr_q <= block_addr_d;
        end
    end

    // Next-state logic for the fill sequencer.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        return_cnt_d = return_cnt_q;
        block_addr_d = block_addr_q;

        case (state_q)
            StIdle: begin
                if (bus.miss_detected) begin
                    block_addr_d = bus.miss_address[ADDR_WIDTH-1:4];
                    issue_cnt_d  = '0;
                    return_cnt_d = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                issue_cnt_d = issue_cnt_q + 3'd1;
                if (issue_cnt_q == LastWord) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StDrain;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Returns may overlap the issue phase; both phases count them the same way.
        if (accept) begin
            return_cnt_d = return_cnt_q + 3'd1;
        end

        // Completion wins over everything else; the counter wraps to zero here.
        if (last_return) begin
            state_d = StIdle;
        end
    end

    // Registered-state decode onto the bus; nothing here depends on miss_detected.
    always_comb begin
        bus.fsm_busy         = (state_q != StIdle);
        bus.mem_enable       = (state_q == StIssue);
        bus.memory_address   = '0;
        if (state_q == StIssue) begin
            bus.memory_address = {block_addr_q, issue_cnt_q, 1'b0};
        end
        bus.write_data_array = accept;
        bus.data_word_sel    = return_cnt_q;
        bus.fill_data        = bus.memory_data;
        bus.write_tag_array  = last_return;
        bus.fill_block_addr  = block_addr_q;
    end

    // Structural invariants of the sequencer.
    a_tag_with_data : assert property (@(posedge clk) disable iff (!rst_n)
        bus.write_tag_array |-> bus.write_data_array);
    a_enable_only_issue : assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_enable |-> (state_q == StIssue));
    a_idle_quiet : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StIdle) |-> !(bus.write_data_array || bus.mem_enable));

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model.
// Returned data is the read address XOR 16'h5A5A.
module tb_cache_fill_fsm;

    logic clk;
    logic rst_n;

    cache_fill_if #(.ADDR_WIDTH(16)) bus ();

    cache_fill_fsm #(
        .ADDR_WIDTH     (16),
        .WORDS_PER_BLOCK(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: request seen at edge E returns in the cycle starting at E+3,
    // i.e. 4 cycles after the request cycle. Flushed by the shared reset.
    logic        pipe_v [4];
    logic [15:0] pipe_a [4];
    logic        spur_valid;
    logic [15:0] spur_data;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= 16'h0;
            end
        end else begin
            pipe_v[0] <= bus.mem_enable;
            pipe_a[0] <= bus.memory_address;
            for (int i = 1; i < 4; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end

    assign bus.memory_data_valid = pipe_v[3] | spur_valid;
    assign bus.memory_data       = spur_valid ? spur_data : (pipe_a[3] ^ 16'h5A5A);

    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    // Checks one idle cycle, then advances to just after the next rising edge.
    task automatic idle_cycle(input logic [11:0] exp_blk);
        @(negedge clk);
        check_eq("idle_busy",   bus.fsm_busy,         0);
        check_eq("idle_mem_en", bus.mem_enable,       0);
        check_eq("idle_addr",   bus.memory_address,   0);
        check_eq("idle_wr",     bus.write_data_array, 0);
        check_eq("idle_sel",    bus.data_word_sel,    0);
        check_eq("idle_tag",    bus.write_tag_array,  0);
        check_eq("idle_blk",    bus.fill_block_addr,  exp_blk);
        @(posedge clk);
        #1;
    endtask

    // Checks fill cycle k (k=0 is the first request cycle), then advances.
    task automatic fill_cycle(input logic [15:0] base, input int k);
        logic        in_ret;
        logic [15:0] ea;
        in_ret = (k >= 4) && (k <= 11);
        ea     = (k < 8) ? base + 16'(2 * k) : 16'h0;
        @(negedge clk);
        check_eq("busy",     bus.fsm_busy,         (k < 12));
        check_eq("mem_en",   bus.mem_enable,       (k < 8));
        check_eq("mem_addr", bus.memory_address,   ea);
        check_eq("wr_data",  bus.write_data_array, in_ret);
        check_eq("word_sel", bus.data_word_sel,    in_ret ? k - 4 : 0);
        if (in_ret) begin
            check_eq("fill_data", bus.fill_data, (base + 16'(2 * (k - 4))) ^ 16'h5A5A);
        end
        check_eq("wr_tag",   bus.write_tag_array,  (k == 11));
        check_eq("blk_addr", bus.fill_block_addr,  base[15:4]);
        @(posedge clk);
        #1;
    endtask

    // Presents a miss so that the next rising edge samples it.
    task automatic start_fill(input logic [15:0] addr, input logic hold);
        bus.miss_detected = 1'b1;
        bus.miss_address  = addr;
        @(posedge clk);
        #1;
        if (!hold) bus.miss_detected = 1'b0;
    endtask

    initial begin
        n_vec             = 0;
        n_err             = 0;
        rst_n             = 1'b0;
        spur_valid        = 1'b0;
        spur_data         = 16'hBEEF;
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h1236;

        // Reset held for three edges with a miss pending.
        @(posedge clk);
        #1;
        idle_cycle(12'h000);
        idle_cycle(12'h000);
        rst_n             = 1'b1;
        bus.miss_detected = 1'b0;
        idle_cycle(12'h000);

        // Single fill from an unaligned byte address.
        start_fill(16'h1236, 1'b0);
        for (int k = 0; k < 13; k++) fill_cycle(16'h1230, k);
        idle_cycle(12'h123);

        // Back-to-back: miss held high; address changes during the first fill.
        start_fill(16'h2002, 1'b1);
        for (int k = 0; k < 13; k++) begin
            if (k == 1) bus.miss_address = 16'hABC0;
            fill_cycle(16'h2000, k);
        end
        for (int k = 0; k < 13; k++) begin
            if (k == 0) bus.miss_detected = 1'b0;
            fill_cycle(16'hABC0, k);
        end

        // Address and miss change mid-fill are ignored.
        start_fill(16'h7770, 1'b0);
        for (int k = 0; k < 13; k++) begin
            if (k == 3) begin
                bus.miss_address  = 16'h5550;
                bus.miss_detected = 1'b1;
            end
            if (k == 4) bus.miss_detected = 1'b0;
            fill_cycle(16'h7770, k);
        end

        // Spurious valids while idle.
        spur_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("spur_fill_data", bus.fill_data, 16'hBEEF);
            idle_cycle(12'h777);
        end
        spur_valid = 1'b0;
        start_fill(16'h333E, 1'b0);
        for (int k = 0; k < 13; k++) fill_cycle(16'h3330, k);

        // Reset asserted in cycle 6 of a fill.
        start_fill(16'h6664, 1'b0);
        for (int k = 0; k < 6; k++) fill_cycle(16'h6660, k);
        rst_n = 1'b0;
        fill_cycle(16'h6660, 6);
        rst_n = 1'b1;
        for (int k = 7; k < 13; k++) idle_cycle(12'h000);
        start_fill(16'h888C, 1'b0);
        for (int k = 0; k < 13; k++) fill_cycle(16'h8880, k);
        idle_cycle(12'h888);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
